// File: rtl/mips_lsu_if.sv
// Memory-side bus of the MIPS load/store unit: a req/ack handshake carrying a word
// address, byte enables and lane-replicated write data. The LSU is the master.
interface mips_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mips_lsu.sv
// Multicycle byte/half/word load-store unit with req/ack memory handshake and
// alignment/timeout error reporting. Define LSU_TIMEOUT_EN to build the wait-state timeout.
module mips_lsu #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [DATA_WIDTH-1:0] base,
    input  logic [15:0]           offset,
    input  logic [DATA_WIDTH-1:0] wdata,
    mips_lsu_if.master            mem,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  done,
    output logic                  busy,
    output logic                  err_align,
    output logic                  err_timeout,
    output logic [3:0]            count_state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ADDR   = 4'd1,
        S_ACCESS = 4'd2,
        S_DONE   = 4'd3,
        S_ERR    = 4'd4
    } state_e;

    state_e                state_q, state_d;
    logic                  is_store_q, is_store_d;
    logic [1:0]            size_q, size_d;
    logic                  sign_ext_q, sign_ext_d;
    logic [DATA_WIDTH-1:0] base_q, base_d;
    logic [15:0]           offset_q, offset_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_align_q, err_align_d;
    logic                  err_timeout_q, err_timeout_d;

    logic [ADDR_WIDTH-1:0] ea;
    logic [3:0]            lane_be;
    logic [DATA_WIDTH-1:0] lane_wdata;
    logic [DATA_WIDTH-1:0] load_val;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic                  misaligned;
    logic                  in_access;
    logic                  wait_expired;

    // Effective address is recomputed from latched operands, so it is stable through ACCESS.
    assign ea = base_q[ADDR_WIDTH-1:0] + {{(ADDR_WIDTH-16){offset_q[15]}}, offset_q};

    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
        misaligned = 1'b0;
        case (size_q)
            2'b00: begin
                lane_be    = 4'b0001 << ea[1:0];
                lane_wdata = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_be    = ea[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata_q[15:0]}};
                misaligned = ea[0];
            end
            default: begin
                misaligned = (ea[1:0] != 2'b00);
            end
        endcase
    end

    always_comb begin
        ld_byte  = mem.mem_rdata[7:0];
        case (ea[1:0])
            2'b00:   ld_byte = mem.mem_rdata[7:0];
            2'b01:   ld_byte = mem.mem_rdata[15:8];
            2'b10:   ld_byte = mem.mem_rdata[23:16];
            default: ld_byte = mem.mem_rdata[31:24];
        endcase
        ld_half  = ea[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        load_val = mem.mem_rdata;
        case (size_q)
            2'b00:   load_val = {{(DATA_WIDTH-8){sign_ext_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_val = {{(DATA_WIDTH-16){sign_ext_q & ld_half[15]}}, ld_half};
            default: load_val = mem.mem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    logic [WAIT_W-1:0] wait_q, wait_d;

    // Counts ACCESS cycles already spent without ack; the last allowed cycle is MAX_WAIT-1.
    assign wait_expired = (wait_q == WAIT_W'(MAX_WAIT - 1));

    always_comb begin
        wait_d = wait_q;
        if (state_q == S_ADDR) begin
            wait_d = '0;
        end else if (state_q == S_ACCESS && !mem.mem_ack && !wait_expired) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    logic unused_max_wait;

    assign wait_expired    = 1'b0;
    assign unused_max_wait = ^MAX_WAIT;
`endif

    always_comb begin
        state_d       = state_q;
        is_store_d    = is_store_q;
        size_d        = size_q;
        sign_ext_d    = sign_ext_q;
        base_d        = base_q;
        offset_d      = offset_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        err_align_d   = err_align_q;
        err_timeout_d = err_timeout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_store_d    = is_store;
                    size_d        = size;
                    sign_ext_d    = sign_ext;
                    base_d        = base;
                    offset_d      = offset;
                    wdata_d       = wdata;
                    err_align_d   = 1'b0;
                    err_timeout_d = 1'b0;
                    state_d       = S_ADDR;
                end
            end
            S_ADDR: begin
                if (misaligned) begin
                    err_align_d = 1'b1;
                    state_d     = S_ERR;
                end else begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Ack wins over timeout so an ack on the final allowed cycle is a success.
                if (mem.mem_ack) begin
                    if (!is_store_q) begin
                        rdata_d = load_val;
                    end
                    state_d = S_DONE;
                end else if (wait_expired) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            is_store_q    <= 1'b0;
            size_q        <= 2'b00;
            sign_ext_q    <= 1'b0;
            base_q        <= '0;
            offset_q      <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            err_align_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            is_store_q    <= is_store_d;
            size_q        <= size_d;
            sign_ext_q    <= sign_ext_d;
            base_q        <= base_d;
            offset_q      <= offset_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            err_align_q   <= err_align_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    // Bus outputs are forced to zero outside ACCESS so nothing leaks onto memory while idle.
    assign in_access     = (state_q == S_ACCESS);
    assign mem.mem_req   = in_access;
    assign mem.mem_we    = in_access & is_store_q;
    assign mem.mem_addr  = in_access ? {ea[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign mem.mem_be    = in_access ? lane_be : 4'b0000;
    assign mem.mem_wdata = in_access ? lane_wdata : '0;

    assign rdata       = rdata_q;
    assign done        = (state_q == S_DONE) || (state_q == S_ERR);
    assign busy        = (state_q != S_IDLE);
    assign err_align   = err_align_q;
    assign err_timeout = err_timeout_q;
    assign count_state = state_q;

endmodule
